decode_issue: RTL and testbench
===============================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 The block SHALL have the parameters below, one per line: name, default, meaning.
- NREGS, 32, register count; index width 5
- IMM_W, 16, instruction immediate width before sign extension
REQ-002 The block SHALL have the ports below, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  block accepts instruction this cycle
- instr  in  32  instruction word
- flush  in  1  discard the held decoded instruction
- out_valid  out  1  decoded bundle valid toward datapath
- out_ready  in  1  datapath accepts bundle
- op  out  1  ALU operation: 0 add, 1 sub
- addr_a  out  5  source A register
- addr_b  out  5  source B register
- addr_d  out  5  destination register
- immed  out  32  sign-extended immediate
- y_sel  out  1  0 selects immed, 1 selects register B
- write  out  1  register-file write enable for this bundle
- wb_valid  in  1  a register write has completed
- wb_addr  in  5  register written back
- illegal  out  1  one-cycle pulse when an undefined opcode is accepted

Function
REQ-003 Decoding SHALL use: opcode=instr[31:26], rd=instr[25:21], ra=instr[20:16], rb=instr[15:11], imm=instr[15:0].
REQ-004 Opcode decoding SHALL be: 0x00 ADD (op0,y_sel1,write1); 0x01 SUB (op1,y_sel1,write1); 0x02 ADDI (op0,y_sel0,write1); 0x03 SUBI (op1,y_sel0,write1); 0x3F NOP (write0).
REQ-005 Any other opcode SHALL be accepted, pulse illegal for one cycle, and produce no output bundle.
REQ-006 immed SHALL equal imm sign-extended to 32 bits for every opcode; for example, imm=0x8001 gives 0xFFFF8001.
REQ-007 A single output register SHALL hold the bundle, giving one-cycle latency from acceptance to out_valid.
REQ-008 The block SHALL keep a 32-bit pending mask with one bit per register that has a write in flight.
REQ-009 The mask bit for addr_d SHALL be set when out_valid&&out_ready&&write.
REQ-010 The mask bit for wb_addr SHALL be cleared when wb_valid is high.
REQ-011 If a set and a clear hit the same index in the same cycle, the set SHALL win.
REQ-012 The hazard check SHALL use an effective mask: the registered mask with the same-cycle wb clear applied, plus the held bundle's addr_d when out_valid&&write.
REQ-013 hazard SHALL be 1 when the incoming instruction's ra is in the effective mask, or its rb is with y_sel=1, or its rd is with write=1; NOP and illegal opcodes never raise hazard.
REQ-014 in_ready SHALL equal (!out_valid || out_ready) && !hazard, evaluated combinationally on instr.
REQ-015 While out_valid=1 and out_ready=0, all bundle outputs SHALL hold stable.
REQ-016 flush SHALL clear out_valid next cycle, SHALL leave the pending mask unchanged, and SHALL force in_ready=0 in the cycle it is asserted.
REQ-017 A flushed bundle SHALL never set a pending bit.
REQ-018 wb_valid for a register with no pending bit SHALL be ignored, with no error.

Reset
REQ-019 While rst=1, out_valid, illegal and the whole pending mask SHALL be 0, and in_ready SHALL be 0.
REQ-020 While rst=1, op, addr_a, addr_b, addr_d, y_sel and write SHALL be 0, and immed SHALL be 0x00000000.
REQ-021 Reset asserted mid-operation SHALL discard the held bundle and all pending bits immediately, without waiting for a clock edge.

Verification
REQ-022 ADDI with rd=3, ra=1, imm=0xFFFE, out_ready=1 -> next cycle out_valid=1, op=0, y_sel=0, immed=0xFFFFFFFE, addr_d=3, write=1; pending[3]=1 after the handshake.
REQ-023 ADD r4=r3+r2 presented while pending[3]=1 -> in_ready=0; then wb_valid with wb_addr=3 -> in_ready=1 in that same cycle and the instruction issues.
REQ-024 SUB r5=r6-r7 followed back-to-back by ADD r8=r5+r1 with out_ready=1 -> the second instruction stalls on the held-bundle rd match and issues only after the wb of r5.
REQ-025 out_ready=0 for 3 cycles with a bundle held -> outputs stable and in_ready=0; out_ready=1 -> bundle consumed, next instruction accepted the same cycle.
REQ-026 Opcode 0x15 -> illegal pulses one cycle, out_valid stays 0; then flush with a held ADD r9 -> out_valid=0 and pending[9] stays 0.
REQ-027 rst asserted with pending[2]=1 and out_valid=1 -> mask=0 and out_valid=0 asynchronously; ADD r2 accepted right after reset deassertion.

Source files
------------

// File: rtl/decode_issue.sv
// decode_issue: single-stage decoder with a registered issue bundle and a pending-write scoreboard.
module decode_issue #(
  parameter int NREGS = 32,
  parameter int IMM_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     op,
  output logic [$clog2(NREGS)-1:0] addr_a,
  output logic [$clog2(NREGS)-1:0] addr_b,
  output logic [$clog2(NREGS)-1:0] addr_d,
  output logic [31:0]              immed,
  output logic                     y_sel,
  output logic                     write,
  input  logic                     wb_valid,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  output logic                     illegal
);
  localparam int AW = $clog2(NREGS);
  localparam logic [NREGS-1:0] ONE = NREGS'(1);
  logic [5:0]       w_opc;
  logic [AW-1:0]    w_rd, w_ra, w_rb;
  logic [31:0]      w_imm;
  logic             w_alu, w_legal, w_op, w_ysel, w_hazard, w_acc;
  logic [NREGS-1:0] w_clr, w_set, w_eff;
  logic [NREGS-1:0] r_pend;
  logic             r_valid, r_ill, r_op, r_ysel, r_write;
  logic [AW-1:0]    r_a, r_b, r_d;
  logic [31:0]      r_imm;
  assign w_opc   = instr[31:26];
  assign w_rd    = instr[21 +: AW];
  assign w_ra    = instr[16 +: AW];
  assign w_rb    = instr[11 +: AW];
  assign w_imm   = {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  assign w_alu   = w_opc <= 6'd3;
  assign w_legal = w_alu || (&w_opc);
  assign w_op    = w_alu && w_opc[0];
  assign w_ysel  = w_alu && !w_opc[1];
  // Every ALU opcode writes rd, so the rd check applies to all of them.
  assign w_clr    = wb_valid ? ONE << wb_addr : '0;
  assign w_eff    = (r_pend & ~w_clr) | ((r_valid && r_write) ? ONE << r_d : '0);
  assign w_hazard = w_alu && (w_eff[w_ra] || (w_ysel && w_eff[w_rb]) || w_eff[w_rd]);
  assign in_ready = !rst && !flush && (!r_valid || out_ready) && !w_hazard;
  assign w_acc    = in_valid && in_ready;
  assign w_set    = (r_valid && out_ready && r_write && !flush) ? ONE << r_d : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_ill   <= 1'b0;
      r_op    <= 1'b0;
      r_ysel  <= 1'b0;
      r_write <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_imm   <= '0;
    end else begin
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_ill   <= w_acc && !w_legal;
      r_valid <= flush ? 1'b0 : w_acc ? w_legal : out_ready ? 1'b0 : r_valid;
      if (w_acc && w_legal) begin
        r_op    <= w_op;
        r_ysel  <= w_ysel;
        r_write <= w_alu;
        r_a     <= w_ra;
        r_b     <= w_rb;
        r_d     <= w_rd;
        r_imm   <= w_imm;
      end
    end
  end
  assign out_valid = r_valid;
  assign illegal   = r_ill;
  assign op        = r_op;
  assign y_sel     = r_ysel;
  assign write     = r_write;
  assign addr_a    = r_a;
  assign addr_b    = r_b;
  assign addr_d    = r_d;
  assign immed     = r_imm;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed steps with a scoreboard of expected issue bundles.
module tb_decode_issue;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] instr = 0, immed;
  logic op, y_sel, write, wb_valid = 0, illegal;
  logic [4:0] addr_a, addr_b, addr_d, wb_addr = 0;
  int total = 0, bad = 0;
  logic exp_ill = 0;
  logic [49:0] q[$];

  decode_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op(op),
    .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d), .immed(immed),
    .y_sel(y_sel), .write(write), .wb_valid(wb_valid), .wb_addr(wb_addr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [5:0] opc, input logic [4:0] rd, ra, input logic [15:0] imm);
    return {opc, rd, ra, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [5:0] opc, input logic [4:0] rd, ra, rb);
    return {opc, rd, ra, rb, 11'd0};
  endfunction

  function automatic logic legal(input logic [31:0] w);
    return w[31:26] <= 6'd3 || w[31:26] == 6'h3F;
  endfunction

  // Bundle layout: {op, addr_a, addr_b, addr_d, immed, y_sel, write}.
  function automatic logic [49:0] dec(input logic [31:0] w);
    logic [5:0] o;
    logic opv, ys, wr;
    o = w[31:26];
    opv = (o == 6'd1) || (o == 6'd3);
    ys = (o == 6'd0) || (o == 6'd1);
    wr = o <= 6'd3;
    return {opv, w[20:16], w[15:11], w[25:21], {{16{w[15]}}, w[15:0]}, ys, wr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl,
                      input logic wbv, input logic [4:0] wba, input logic exp_rdy);
    in_valid = v; instr = w; out_ready = ordy; flush = fl; wb_valid = wbv; wb_addr = wba;
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("illegal", 64'(illegal), 64'(exp_ill));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk("bundle", 64'({op, addr_a, addr_b, addr_d, immed, y_sel, write}), 64'(q[0]));
    @(posedge clk);
    exp_ill = v && exp_rdy && !legal(w);
    if (fl) q.delete();
    else if (ordy && q.size() > 0) void'(q.pop_front());
    if (v && exp_rdy && legal(w)) q.push_back(dec(w));
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_bundle", 64'({op, addr_a, addr_b, addr_d, immed, y_sel, write}), 64'(0));
  endtask

  initial begin
    in_valid = 1; instr = ins(6'd2, 5'd1, 5'd2, 16'h0005);
    @(negedge clk); @(negedge clk);
    chk_reset_outputs();
    rst = 0; in_valid = 0;
    // ADDI r3 = r1 + 0xFFFE, then ADD r4 = r3 + r2 stalls until wb of r3
    step(1, ins(6'd2, 5'd3, 5'd1, 16'hFFFE), 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    step(1, rr(6'd0, 5'd4, 5'd3, 5'd2), 1, 0, 0, 0, 0);
    step(1, rr(6'd0, 5'd4, 5'd3, 5'd2), 1, 0, 1, 5'd3, 1);
    // Set of r4 and clear of r4 in the same cycle: set wins
    step(0, 0, 1, 0, 1, 5'd4, 1);
    step(1, rr(6'd0, 5'd10, 5'd4, 5'd0), 1, 0, 0, 0, 0);
    step(1, rr(6'd0, 5'd10, 5'd4, 5'd0), 1, 0, 1, 5'd4, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 5'd10, 1);
    // SUB r5 then ADD r8 = r5 + r1 back to back
    step(1, rr(6'd1, 5'd5, 5'd6, 5'd7), 1, 0, 0, 0, 1);
    step(1, rr(6'd0, 5'd8, 5'd5, 5'd1), 1, 0, 0, 0, 0);
    step(1, rr(6'd0, 5'd8, 5'd5, 5'd1), 1, 0, 0, 0, 0);
    step(1, rr(6'd0, 5'd8, 5'd5, 5'd1), 1, 0, 1, 5'd5, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 5'd8, 1);
    // Backpressure: held bundle stays stable for 3 cycles
    step(1, rr(6'd0, 5'd11, 5'd1, 5'd2), 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, rr(6'd0, 5'd12, 5'd1, 5'd2), 0, 0, 0, 0, 0);
    step(1, rr(6'd0, 5'd12, 5'd1, 5'd2), 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 5'd11, 1);
    step(0, 0, 1, 0, 1, 5'd12, 1);
    // Illegal opcode: one-cycle pulse, no bundle
    step(1, ins(6'h15, 5'd3, 5'd3, 16'h1800), 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    // Flush a held ADD r9 while out_ready=1: r9 must not become pending
    step(1, rr(6'd0, 5'd9, 5'd1, 5'd2), 0, 0, 0, 0, 1);
    step(0, rr(6'd0, 5'd1, 5'd1, 5'd1), 1, 1, 0, 0, 0);
    step(1, rr(6'd0, 5'd13, 5'd9, 5'd9), 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    // NOP ignores pending registers; SUBI on pending r13 stalls
    step(1, rr(6'h3F, 5'd13, 5'd13, 5'd13), 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    step(1, ins(6'd3, 5'd14, 5'd13, 16'h0005), 1, 0, 0, 0, 0);
    step(1, ins(6'd3, 5'd14, 5'd13, 16'h0005), 1, 0, 1, 5'd13, 1);
    step(0, 0, 1, 0, 1, 5'd20, 1);
    // ADDI r2 with imm 0x8001, then hold an ADD r15 and reset asynchronously
    step(1, ins(6'd2, 5'd2, 5'd0, 16'h8001), 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    step(1, rr(6'd0, 5'd15, 5'd1, 5'd1), 0, 0, 0, 0, 1);
    in_valid = 0; out_ready = 0;
    #2 rst = 1;
    #1 chk_reset_outputs();
    q.delete();
    exp_ill = 0;
    @(negedge clk);
    rst = 0;
    step(1, rr(6'd0, 5'd2, 5'd2, 5'd2), 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
